// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder driving an external 1-bit full adder cell, LSB first
// ports: clk/rst_n (async active-low); start, a, b, cin request and operands; fa_a/fa_b/fa_cin to the cell,
//   fa_s/fa_cout from it; sum/cout result held until the next completion; busy while not idle; done one-cycle pulse
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_nxt;
  logic [WIDTH-2:0] sum_sh;
  logic carry;
  logic [CW-1:0] cnt;
  // partial sum with the current bit shifted in; only the top WIDTH-1 bits need storing
  assign sum_nxt = {fa_s, sum_sh};
  assign busy = state != IDLE;
  assign fa_a = state == SHIFT && a_sh[0];
  assign fa_b = state == SHIFT && b_sh[0];
  assign fa_cin = state == SHIFT && carry;
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (start ? SHIFT : IDLE) :
          state == SHIFT ? (cnt == LAST ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        carry <= cin;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        sum_sh <= sum_nxt[WIDTH-1:1];
        carry <= fa_cout;
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          sum <= sum_nxt;
          cout <= fa_cout;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of serial_adder_ctrl at WIDTH=8 plus exhaustive WIDTH=4
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int passed = 0;
  logic start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic fa_a8, fa_b8, fa_cin8, fa_s8, fa_cout8, cout8, busy8, done8;
  logic start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic fa_a4, fa_b4, fa_cin4, fa_s4, fa_cout4, cout4, busy4, done4;
  int lat, bcyc, dones;
  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_s(fa_s8), .fa_cout(fa_cout8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );
  fulladder fa8 (.a(fa_a8), .b(fa_b8), .cin(fa_cin8), .s(fa_s8), .cout(fa_cout8));
  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_s(fa_s4), .fa_cout(fa_cout4),
    .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
  );
  fulladder fa4 (.a(fa_a4), .b(fa_b4), .cin(fa_cin4), .s(fa_s4), .cout(fa_cout4));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, output int l, output int bc);
    a8 = x;
    b8 = y;
    cin8 = c;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    l = 0;
    bc = 0;
    while (!done8 && l < 40) begin
      bc += int'(busy8);
      @(negedge clk);
      l++;
    end
    bc += int'(busy8);
  endtask
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c, output int l);
    a4 = x;
    b4 = y;
    cin4 = c;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    l = 0;
    while (!done4 && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask
  initial begin
    #1;
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", cout8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_fa", {fa_a8, fa_b8, fa_cin8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op8(8'h5A, 8'h3C, 1'b0, lat, bcyc);
    chk("t1_latency", lat, 8);
    chk("t1_busy_cycles", bcyc, 9);
    chk("t1_sum", sum8, 8'h96);
    chk("t1_cout", cout8, 0);
    chk("t1_done", done8, 1);
    chk("t1_fa_in_done", {fa_a8, fa_b8, fa_cin8}, 0);
    @(negedge clk);
    chk("t1_done_drop", done8, 0);
    chk("t1_idle", busy8, 0);
    chk("t1_sum_hold", sum8, 8'h96);
    op8(8'hFF, 8'h01, 1'b0, lat, bcyc);
    @(negedge clk);
    chk("t2_sum", sum8, 8'h00);
    chk("t2_cout", cout8, 1);
    op8(8'hFF, 8'hFF, 1'b1, lat, bcyc);
    @(negedge clk);
    chk("t3a_sum", sum8, 8'hFF);
    chk("t3a_cout", cout8, 1);
    op8(8'h00, 8'h00, 1'b0, lat, bcyc);
    @(negedge clk);
    chk("t3b_sum", sum8, 8'h00);
    chk("t3b_cout", cout8, 0);
    a8 = 8'h12;
    b8 = 8'hF4;
    cin8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF;
    b8 = 8'hFF;
    cin8 = 1'b1;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    dones = int'(done8);
    chk("t4_latency", lat, 8);
    chk("t4_sum", sum8, 8'h06);
    chk("t4_cout", cout8, 1);
    repeat (12) begin
      @(negedge clk);
      dones += int'(done8);
    end
    chk("t4_done_count", dones, 1);
    chk("t4_idle", busy8, 0);
    a8 = 8'h5A;
    b8 = 8'h3C;
    cin8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy8, 0);
    chk("t5_sum", sum8, 8'h00);
    chk("t5_cout", cout8, 0);
    dones = int'(done8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      dones += int'(done8);
    end
    chk("t5_no_done", dones, 0);
    op8(8'h5A, 8'h3C, 1'b0, lat, bcyc);
    chk("t5_latency", lat, 8);
    chk("t5_sum_after", sum8, 8'h96);
    chk("t5_cout_after", cout8, 0);
    @(negedge clk);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          op4(4'(x), 4'(y), 1'(c), lat);
          chk("t6_result", {cout4, sum4}, 32'(x + y + c));
          chk("t6_fa_done", {fa_a4, fa_b4, fa_cin4, 1'b0, lat == 4}, 5'b00001);
          @(negedge clk);
          chk("t6_fa_idle", {fa_a4, fa_b4, fa_cin4, busy4}, 0);
        end
    chk("t6_fa8_idle", {fa_a8, fa_b8, fa_cin8}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
